i2c_master_tx: RTL and testbench

I2C_MASTER_TX -- requirements
Module: i2c_master_tx

---
 rtl/i2c_pkg.sv | 28 ++
 rtl/i2c_qtick.sv | 43 ++++
 rtl/i2c_master_tx.sv | 229 ++++++++++++++++++++++
 tb/tb_i2c_master_tx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2c_pkg
// Purpose  : Shared types and constants for the I2C write-only master.
//            i2c_state_t : controller state encoding (explicit 3-bit values)
//            SDA_RELEASE : sda_out level that lets the line float high
//            ADDR_WRITE_BIT : R/W bit appended to the 7-bit slave address
// Revision : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_ADDR     = 3'd2,
        S_ADDR_ACK = 3'd3,
        S_WAIT     = 3'd4,
        S_DATA     = 3'd5,
        S_DATA_ACK = 3'd6,
        S_STOP     = 3'd7
    } i2c_state_t;

    localparam logic SDA_RELEASE    = 1'b1;
    localparam logic ADDR_WRITE_BIT = 1'b0;

endpackage
`default_nettype wire

// File: rtl/i2c_qtick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2c_qtick
// Purpose  : SCL quarter-period divider. Counts 0..QDIV-1 while enabled and
//            pulses tick during the QDIV-1 count; held at 0 when disabled.
// Ports    : clk    - system clock
//            rst    - asynchronous active-high reset
//            enable - run the divider
//            tick   - one-cycle pulse marking the end of a quarter
// Params   : QDIV   - system clocks per quarter (must be >= 2)
// Revision : 1.0 - initial release
// ============================================================================
module i2c_qtick #(
    parameter int QDIV = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int CW = (QDIV > 2) ? $clog2(QDIV) : 1;
    localparam logic [CW-1:0] c_last = CW'(QDIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!enable) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = enable && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/i2c_master_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2c_master_tx
// Purpose  : Write-only I2C master. Sends START, 7-bit address + W, then
//            data bytes from a one-entry holding buffer, checking each ACK,
//            and finishes with STOP. SCL is stretched low while waiting for
//            the next byte.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            cmd_start, cmd_addr - start request and 7-bit slave address
//            tx_valid, tx_data, tx_last, tx_ready - byte stream handshake
//            sda_in              - synchronised SDA line
//            sda_out, scl_out    - open-drain controls (1 = release)
//            busy, done, nack    - transaction status
// Params   : QDIV - system clocks per SCL quarter period (>= 2)
// Revision : 1.0 - initial release
// ============================================================================
module i2c_master_tx
    import i2c_pkg::*;
#(
    parameter int QDIV = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_start,
    input  logic [6:0] cmd_addr,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       scl_out,
    output logic       busy,
    output logic       done,
    output logic       nack
);

    i2c_state_t r_state;
    logic [1:0] r_qtr;
    logic [2:0] r_bit;
    logic [7:0] r_shift;
    logic       r_last;
    logic       r_ack;
    logic       r_nack_flag;
    logic       r_done;
    logic       r_nack;

    logic [7:0] r_buf_data;
    logic       r_buf_last;
    logic       r_buf_full;

    logic w_tick;
    logic w_div_en;
    logic w_qend;
    logic w_ack_ok_more;
    logic w_load;
    logic w_buf_wr;
    logic w_flush;

    // The divider is frozen in WAIT so a freshly loaded byte always starts
    // with a full-length first quarter.
    assign w_div_en = (r_state != S_IDLE) && (r_state != S_WAIT);

    i2c_qtick #(
        .QDIV   (QDIV)
    ) u_qtick (
        .clk    (clk),
        .rst    (rst),
        .enable (w_div_en),
        .tick   (w_tick)
    );

    assign w_qend = w_tick && (r_qtr == 2'd3);

    // ACK phase ending with an ACK and more data to send.
    assign w_ack_ok_more = w_qend && !r_ack &&
                           ((r_state == S_ADDR_ACK) ||
                            ((r_state == S_DATA_ACK) && !r_last));

    // A full buffer at the end of an ACK is loaded directly, so WAIT has zero
    // duration and back-to-back bytes incur no extra SCL time.
    assign w_load   = r_buf_full && ((r_state == S_WAIT) || w_ack_ok_more);
    assign w_buf_wr = tx_valid && !r_buf_full;
    // Aborted transfers discard whatever is still queued.
    assign w_flush  = w_qend && (r_state == S_STOP) && r_nack_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_full <= 1'b0;
            r_buf_data <= 8'h00;
            r_buf_last <= 1'b0;
        end else if (w_flush || w_load) begin
            r_buf_full <= 1'b0;
        end else if (w_buf_wr) begin
            r_buf_full <= 1'b1;
            r_buf_data <= tx_data;
            r_buf_last <= tx_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_qtr       <= 2'd0;
            r_bit       <= 3'd0;
            r_shift     <= 8'h00;
            r_last      <= 1'b0;
            r_ack       <= 1'b0;
            r_nack_flag <= 1'b0;
            r_done      <= 1'b0;
            r_nack      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_nack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_start) begin
                        r_shift     <= {cmd_addr, ADDR_WRITE_BIT};
                        r_qtr       <= 2'd0;
                        r_bit       <= 3'd0;
                        r_nack_flag <= 1'b0;
                        r_state     <= S_START;
                    end
                end
                S_WAIT: begin
                    if (w_load) begin
                        r_shift <= r_buf_data;
                        r_last  <= r_buf_last;
                        r_state <= S_DATA;
                    end
                end
                default: begin
                    if (w_tick) begin
                        r_qtr <= r_qtr + 2'd1;
                        if ((r_qtr == 2'd2) &&
                            ((r_state == S_ADDR_ACK) || (r_state == S_DATA_ACK))) begin
                            r_ack <= sda_in;
                        end
                        if (r_qtr == 2'd3) begin
                            case (r_state)
                                S_START: begin
                                    r_bit   <= 3'd0;
                                    r_state <= S_ADDR;
                                end
                                S_ADDR, S_DATA: begin
                                    // r_bit wraps back to 0 after bit 7.
                                    r_bit   <= r_bit + 3'd1;
                                    r_shift <= {r_shift[6:0], 1'b0};
                                    if (r_bit == 3'd7) begin
                                        r_state <= (r_state == S_ADDR) ? S_ADDR_ACK
                                                                       : S_DATA_ACK;
                                    end
                                end
                                S_ADDR_ACK, S_DATA_ACK: begin
                                    if (r_ack) begin
                                        r_nack_flag <= 1'b1;
                                        r_state     <= S_STOP;
                                    end else if ((r_state == S_DATA_ACK) && r_last) begin
                                        r_state <= S_STOP;
                                    end else if (w_load) begin
                                        r_shift <= r_buf_data;
                                        r_last  <= r_buf_last;
                                        r_state <= S_DATA;
                                    end else begin
                                        r_state <= S_WAIT;
                                    end
                                end
                                S_STOP: begin
                                    r_done      <= 1'b1;
                                    r_nack      <= r_nack_flag;
                                    r_nack_flag <= 1'b0;
                                    r_state     <= S_IDLE;
                                end
                                default: begin
                                    r_state <= S_IDLE;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    // Line levels are decoded from registered state only, so reset releases
    // both lines without waiting for a clock edge.
    always_comb begin
        scl_out = 1'b1;
        sda_out = SDA_RELEASE;
        case (r_state)
            S_IDLE: begin
                scl_out = 1'b1;
                sda_out = SDA_RELEASE;
            end
            S_START: begin
                scl_out = 1'b1;
                sda_out = !r_qtr[1];
            end
            S_ADDR, S_DATA: begin
                scl_out = r_qtr[1];
                sda_out = r_shift[7];
            end
            S_ADDR_ACK, S_DATA_ACK: begin
                scl_out = r_qtr[1];
                sda_out = SDA_RELEASE;
            end
            S_WAIT: begin
                scl_out = 1'b0;
                sda_out = 1'b0;
            end
            S_STOP: begin
                scl_out = (r_qtr != 2'd0);
                sda_out = r_qtr[1];
            end
            default: begin
                scl_out = 1'b1;
                sda_out = SDA_RELEASE;
            end
        endcase
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign nack     = r_nack;
    assign tx_ready = !r_buf_full;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_master_tx
// Purpose  : Directed self-checking bench for i2c_master_tx (QDIV = 5).
//            The slave is modelled by a constant sda_in level (0 = ACK,
//            1 = NACK); SDA is captured at every SCL rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_master_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_start = 1'b0;
    logic [6:0] cmd_addr = 7'h00;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic       sda_in = 1'b0;
    logic       sda_out;
    logic       scl_out;
    logic       busy;
    logic       done;
    logic       nack;

    int checks = 0;
    int failures = 0;

    int          cyc = 0;
    int          rises = 0;
    logic [63:0] cap = '0;
    logic        scl_q = 1'b1;

    i2c_master_tx #(
        .QDIV      (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_start (cmd_start),
        .cmd_addr  (cmd_addr),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_last   (tx_last),
        .tx_ready  (tx_ready),
        .sda_in    (sda_in),
        .sda_out   (sda_out),
        .scl_out   (scl_out),
        .busy      (busy),
        .done      (done),
        .nack      (nack)
    );

    always #5 clk = ~clk;

    // Cycle counter and SDA capture at each SCL rising edge; cleared when a
    // new command is accepted.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        scl_q <= scl_out;
        if (cmd_start && !busy) begin
            cap   <= '0;
            rises <= 0;
        end else if (scl_out && !scl_q) begin
            cap   <= {cap[62:0], sda_out};
            rises <= rises + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] d, input logic l);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        tx_last  = l;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic start_cmd(input logic [6:0] a, output int t0);
        @(negedge clk);
        cmd_start = 1'b1;
        cmd_addr  = a;
        @(posedge clk);
        #1;
        t0 = cyc;
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input int t0, output int lat, output logic nk);
        int g;
        logic seen;
        g = 0;
        seen = 1'b0;
        lat = -1;
        nk = 1'bx;
        while (g < 4000 && !seen) begin
            @(posedge clk);
            #1;
            g++;
            if (done === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - t0;
                nk   = nack;
            end
        end
        check("done_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_rises(input int n);
        int g;
        g = 0;
        while (g < 4000 && rises < n) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("rise_reached", {31'd0, (rises >= n)}, 32'd1);
    endtask

    initial begin
        int   t0;
        int   lat;
        logic nk;
        logic held;
        int   g;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_scl", {31'd0, scl_out}, 32'd1);
        check("rst_sda", {31'd0, sda_out}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_nack", {31'd0, nack}, 32'd0);
        check("rst_ready", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- T1: one byte 0xA5, addr 0x50, ACK ----------------
        sda_in = 1'b0;
        push_byte(8'hA5, 1'b1);
        check("t1_ready_full", {31'd0, tx_ready}, 32'd0);
        start_cmd(7'h50, t0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_start_scl", {31'd0, scl_out}, 32'd1);
        // A second command while busy must not disturb the transfer.
        repeat (3) @(negedge clk);
        cmd_start = 1'b1;
        cmd_addr  = 7'h7F;
        @(negedge clk);
        cmd_start = 1'b0;
        wait_done(t0, lat, nk);
        // busy spans 400 clocks (80 quarters), done appears in the 401st.
        check("t1_latency", lat, 32'd400);
        check("t1_nack", {31'd0, nk}, 32'd0);
        check("t1_busy_at_done", {31'd0, busy}, 32'd0);
        check("t1_rises", rises, 32'd19);
        check("t1_bits", {13'd0, cap[18:0]}, {13'd0, 19'b1010_0000_1_1010_0101_1_0});
        @(posedge clk);
        #1;
        check("t1_done_pulse", {31'd0, done}, 32'd0);
        check("t1_scl_idle", {31'd0, scl_out}, 32'd1);
        check("t1_sda_idle", {31'd0, sda_out}, 32'd1);

        // ---------------- T2: address NACK ----------------
        sda_in = 1'b1;
        push_byte(8'h33, 1'b1);
        start_cmd(7'h2A, t0);
        wait_done(t0, lat, nk);
        check("t2_latency", lat, 32'd220);
        check("t2_nack", {31'd0, nk}, 32'd1);
        check("t2_done", {31'd0, done}, 32'd1);
        check("t2_flushed", {31'd0, tx_ready}, 32'd1);
        check("t2_rises", rises, 32'd10);
        check("t2_bits", {22'd0, cap[9:0]}, {22'd0, 10'b0101_0100_1_0});
        @(posedge clk);
        #1;
        check("t2_nack_pulse", {31'd0, nack}, 32'd0);

        // ---------------- T3: two bytes, second late ----------------
        sda_in = 1'b0;
        push_byte(8'h11, 1'b0);
        start_cmd(7'h3C, t0);
        wait_rises(18);
        g = 0;
        while (g < 100 && scl_out !== 1'b0) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("t3_wait_entered", {31'd0, scl_out}, 32'd0);
        check("t3_wait_sda", {31'd0, sda_out}, 32'd0);
        check("t3_wait_ready", {31'd0, tx_ready}, 32'd1);
        held = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (scl_out !== 1'b0 || busy !== 1'b1) held = 1'b0;
        end
        check("t3_scl_held", {31'd0, held}, 32'd1);
        push_byte(8'h22, 1'b1);
        wait_done(t0, lat, nk);
        check("t3_nack", {31'd0, nk}, 32'd0);
        check("t3_rises", rises, 32'd28);
        check("t3_bits", {4'd0, cap[27:0]},
              {4'd0, 28'b0111_1000_1_0001_0001_1_0010_0010_1_0});

        // ---------------- T4: reset mid data bit, then recover ----------------
        push_byte(8'hFF, 1'b1);
        start_cmd(7'h11, t0);
        wait_rises(12);
        rst = 1'b1;
        #1;
        check("t4_rst_scl", {31'd0, scl_out}, 32'd1);
        check("t4_rst_sda", {31'd0, sda_out}, 32'd1);
        check("t4_rst_busy", {31'd0, busy}, 32'd0);
        check("t4_rst_ready", {31'd0, tx_ready}, 32'd1);
        check("t4_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t4_idle_after", {31'd0, busy}, 32'd0);
        push_byte(8'hC3, 1'b1);
        start_cmd(7'h05, t0);
        wait_done(t0, lat, nk);
        check("t4_latency", lat, 32'd400);
        check("t4_nack", {31'd0, nk}, 32'd0);
        check("t4_rises", rises, 32'd19);
        check("t4_bits", {13'd0, cap[18:0]}, {13'd0, 19'b0000_1010_1_1100_0011_1_0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
